// File: rtl/uart_top_ip.sv
// uart_top_ip: full-duplex UART transceiver.
//
// A free-running divider produces an oversampling tick at BAUD_RATE_HZ * OVER_SAMPLING.
// The transmitter holds each bit for OVER_SAMPLING ticks. The receiver finds the start
// bit, checks it again at mid-bit, and then samples each following bit at its centre.
// Frame layout: start bit, DATA_FRAME_LENGTH data bits sent LSB first, an optional even
// parity bit, then STOP_BIT_LENGTH stop bits.
//
// Optional feature: when `UART_RX_SYNC2_EN is defined, rx passes through a 2-flop
// synchronizer instead of a single input register. This adds one cycle of receive
// latency and changes nothing else.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   tx            out  serial output, idle high
//   rx            in   serial input, asynchronous to clk
//   tx_data       in   word to send, latched when a frame starts
//   tx_data_en    in   transmit request; a rising edge starts a frame
//   tx_data_done  out  high from the end of the last stop bit until the next frame starts
//   rx_data       out  last received word
//   rx_data_en    in   arms start-bit detection
//   rx_data_done  out  high once a frame has been received
//   parity_err    out  parity mismatch on the last received frame
module uart_top_ip #(
    parameter int unsigned SYS_CLK_KHZ       = 100_000,
    parameter int unsigned BAUD_RATE_HZ      = 9600,
    parameter int unsigned OVER_SAMPLING     = 16,
    parameter int unsigned PARITY_BIT_LENGTH = 0,
    parameter int unsigned STOP_BIT_LENGTH   = 1,
    parameter int unsigned DATA_FRAME_LENGTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         tx,
    input  logic                         rx,
    input  logic [DATA_FRAME_LENGTH-1:0] tx_data,
    input  logic                         tx_data_en,
    output logic                         tx_data_done,
    output logic [DATA_FRAME_LENGTH-1:0] rx_data,
    input  logic                         rx_data_en,
    output logic                         rx_data_done,
    output logic                         parity_err
);

    localparam int unsigned DIV_DEN = BAUD_RATE_HZ * OVER_SAMPLING;
    // Divide with rounding to the nearest integer.
    localparam int unsigned DIV     = (SYS_CLK_KHZ * 1000 + DIV_DEN / 2) / DIV_DEN;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W    = $clog2(OVER_SAMPLING);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVER_SAMPLING - 1);
    localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVER_SAMPLING / 2 - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_FRAME_LENGTH - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BIT_LENGTH - 1);
    localparam bit               HAS_PAR   = (PARITY_BIT_LENGTH == 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // ------------------------------------------------------------------ tick generator
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------ transmitter
    state_e                         r_tx_state, w_tx_state_next;
    logic [OS_W-1:0]                r_tx_tick, w_tx_tick_next;
    logic [3:0]                     r_tx_idx, w_tx_idx_next;
    logic [DATA_FRAME_LENGTH-1:0]   r_tx_shift, w_tx_shift_next;
    logic                           r_tx_par, w_tx_par_next;
    logic                           r_tx, w_tx_next;
    logic                           r_tx_done, w_tx_done_next;
    logic                           r_tx_en, r_tx_en_d;
    logic                           w_tx_req;
    logic                           w_tx_bit_end;

    // Only a fresh rising edge of the registered request starts a frame, so a request
    // held high sends one frame.
    assign w_tx_req     = r_tx_en & ~r_tx_en_d;
    assign w_tx_bit_end = w_tick && (r_tx_tick == OS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= StIdle;
            r_tx_tick  <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_en    <= 1'b0;
            r_tx_en_d  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_tick  <= w_tx_tick_next;
            r_tx_idx   <= w_tx_idx_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_par   <= w_tx_par_next;
            r_tx       <= w_tx_next;
            r_tx_done  <= w_tx_done_next;
            r_tx_en    <= tx_data_en;
            r_tx_en_d  <= r_tx_en;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_tick_next  = r_tx_tick;
        w_tx_idx_next   = r_tx_idx;
        w_tx_shift_next = r_tx_shift;
        w_tx_par_next   = r_tx_par;
        w_tx_next       = r_tx;
        w_tx_done_next  = r_tx_done;

        // The tick counter advances on every tick while a frame is in progress.
        if (r_tx_state != StIdle && w_tick) begin
            w_tx_tick_next = w_tx_bit_end ? '0 : r_tx_tick + OS_W'(1);
        end

        unique case (r_tx_state)
            StIdle: begin
                w_tx_next = 1'b1;
                if (w_tx_req) begin
                    w_tx_shift_next = tx_data;
                    w_tx_par_next   = ^tx_data;
                    w_tx_done_next  = 1'b0;
                    w_tx_tick_next  = '0;
                    w_tx_next       = 1'b0;
                    w_tx_state_next = StStart;
                end
            end
            StStart: begin
                if (w_tx_bit_end) begin
                    w_tx_idx_next   = '0;
                    w_tx_next       = r_tx_shift[0];
                    w_tx_state_next = StData;
                end
            end
            StData: begin
                if (w_tx_bit_end) begin
                    if (r_tx_idx == DATA_LAST) begin
                        w_tx_idx_next = '0;
                        if (HAS_PAR) begin
                            w_tx_next       = r_tx_par;
                            w_tx_state_next = StParity;
                        end else begin
                            w_tx_next       = 1'b1;
                            w_tx_state_next = StStop;
                        end
                    end else begin
                        w_tx_idx_next   = r_tx_idx + 4'd1;
                        w_tx_shift_next = r_tx_shift >> 1;
                        w_tx_next       = r_tx_shift[1];
                    end
                end
            end
            StParity: begin
                if (w_tx_bit_end) begin
                    w_tx_idx_next   = '0;
                    w_tx_next       = 1'b1;
                    w_tx_state_next = StStop;
                end
            end
            StStop: begin
                if (w_tx_bit_end) begin
                    if (r_tx_idx == STOP_LAST) begin
                        w_tx_done_next  = 1'b1;
                        w_tx_state_next = StIdle;
                    end else begin
                        w_tx_idx_next = r_tx_idx + 4'd1;
                    end
                end
            end
            default: w_tx_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ rx input register
    logic r_rx_sync;

`ifdef UART_RX_SYNC2_EN
    logic r_rx_meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_sync <= rx;
        end
    end
`endif

    // ------------------------------------------------------------------ receiver
    state_e                         r_rx_state, w_rx_state_next;
    logic [OS_W-1:0]                r_rx_tick, w_rx_tick_next;
    logic [3:0]                     r_rx_idx, w_rx_idx_next;
    logic [DATA_FRAME_LENGTH-1:0]   r_rx_shift, w_rx_shift_next;
    logic                           r_rx_par, w_rx_par_next;
    logic [DATA_FRAME_LENGTH-1:0]   r_rx_data, w_rx_data_next;
    logic                           r_rx_done, w_rx_done_next;
    logic                           r_perr, w_perr_next;
    logic                           w_rx_centre;

    // Counting restarts at the mid-point of the start bit, so every later full bit count
    // ends at a bit centre.
    assign w_rx_centre = w_tick && (r_rx_tick == OS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= StIdle;
            r_rx_tick  <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_done  <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_next;
            r_rx_tick  <= w_rx_tick_next;
            r_rx_idx   <= w_rx_idx_next;
            r_rx_shift <= w_rx_shift_next;
            r_rx_par   <= w_rx_par_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_done  <= w_rx_done_next;
            r_perr     <= w_perr_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_tick_next  = r_rx_tick;
        w_rx_idx_next   = r_rx_idx;
        w_rx_shift_next = r_rx_shift;
        w_rx_par_next   = r_rx_par;
        w_rx_data_next  = r_rx_data;
        w_rx_done_next  = r_rx_done;
        w_perr_next     = r_perr;

        if (r_rx_state != StIdle && w_tick) begin
            w_rx_tick_next = w_rx_centre ? '0 : r_rx_tick + OS_W'(1);
        end

        unique case (r_rx_state)
            StIdle: begin
                if (w_tick && rx_data_en && !r_rx_sync) begin
                    w_rx_tick_next  = '0;
                    w_rx_state_next = StStart;
                end
            end
            StStart: begin
                if (w_tick && (r_rx_tick == OS_MID)) begin
                    w_rx_tick_next = '0;
                    if (!r_rx_sync) begin
                        // Start bit confirmed: the previous result is now stale.
                        w_rx_idx_next   = '0;
                        w_rx_done_next  = 1'b0;
                        w_perr_next     = 1'b0;
                        w_rx_state_next = StData;
                    end else begin
                        // Glitch: drop it and leave the outputs as they are.
                        w_rx_state_next = StIdle;
                    end
                end
            end
            StData: begin
                if (w_rx_centre) begin
                    w_rx_shift_next = {r_rx_sync, r_rx_shift[DATA_FRAME_LENGTH-1:1]};
                    if (r_rx_idx == DATA_LAST) begin
                        w_rx_state_next = HAS_PAR ? StParity : StStop;
                    end else begin
                        w_rx_idx_next = r_rx_idx + 4'd1;
                    end
                end
            end
            StParity: begin
                if (w_rx_centre) begin
                    w_rx_par_next   = r_rx_sync;
                    w_rx_state_next = StStop;
                end
            end
            StStop: begin
                // A low stop bit still delivers the word; framing errors are not flagged.
                if (w_rx_centre) begin
                    w_rx_data_next  = r_rx_shift;
                    w_rx_done_next  = 1'b1;
                    w_perr_next     = HAS_PAR ? (r_rx_par != ^r_rx_shift) : 1'b0;
                    w_rx_state_next = StIdle;
                end
            end
            default: w_rx_state_next = StIdle;
        endcase
    end

    assign tx           = r_tx;
    assign tx_data_done = r_tx_done;
    assign rx_data      = r_rx_data;
    assign rx_data_done = r_rx_done;
    assign parity_err   = r_perr;

endmodule

// File: tb/tb_uart_top_ip.sv
// Bench for uart_top_ip. Instances a and b are cross-connected and run about 2% apart in
// baud rate. Instance p has even parity, and the bench drives its rx line directly.
// Instance s has two stop bits. Each expected frame comes from a bit-list model of the
// line format.
module tb_uart_top_ip;

    localparam int unsigned SYS_KHZ = 3840;
    localparam int BIT_A = 400;  // 8 samples x 50 clocks
    localparam int BIT_B = 392;  // 8 samples x 49 clocks
    localparam int BIT_P = 400;  // 16 samples x 25 clocks
    localparam int BIT_S = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_tx, b_tx, p_tx, s_tx;
    logic [7:0] a_tx_data = '0, b_tx_data = '0, p_tx_data = '0, s_tx_data = '0;
    logic       a_tx_en = 1'b0, b_tx_en = 1'b0, p_tx_en = 1'b0, s_tx_en = 1'b0;
    logic       a_tx_done, b_tx_done, p_tx_done, s_tx_done;
    logic [7:0] a_rx_data, b_rx_data, p_rx_data, s_rx_data;
    logic       a_rx_en = 1'b0, b_rx_en = 1'b0, p_rx_en = 1'b0, s_rx_en = 1'b0;
    logic       a_rx_done, b_rx_done, p_rx_done, s_rx_done;
    logic       a_perr, b_perr, p_perr, s_perr;
    logic       p_rx = 1'b1;
    logic       s_rx = 1'b1;

    int tests = 0;
    int fails = 0;

    uart_top_ip #(.SYS_CLK_KHZ(SYS_KHZ), .BAUD_RATE_HZ(9600), .OVER_SAMPLING(8)) u_a (
        .clk(clk), .rst_n(rst_n), .tx(a_tx), .rx(b_tx),
        .tx_data(a_tx_data), .tx_data_en(a_tx_en), .tx_data_done(a_tx_done),
        .rx_data(a_rx_data), .rx_data_en(a_rx_en), .rx_data_done(a_rx_done),
        .parity_err(a_perr)
    );

    uart_top_ip #(.SYS_CLK_KHZ(SYS_KHZ), .BAUD_RATE_HZ(9800), .OVER_SAMPLING(8)) u_b (
        .clk(clk), .rst_n(rst_n), .tx(b_tx), .rx(a_tx),
        .tx_data(b_tx_data), .tx_data_en(b_tx_en), .tx_data_done(b_tx_done),
        .rx_data(b_rx_data), .rx_data_en(b_rx_en), .rx_data_done(b_rx_done),
        .parity_err(b_perr)
    );

    uart_top_ip #(.SYS_CLK_KHZ(SYS_KHZ), .BAUD_RATE_HZ(9600), .OVER_SAMPLING(16),
                  .PARITY_BIT_LENGTH(1)) u_p (
        .clk(clk), .rst_n(rst_n), .tx(p_tx), .rx(p_rx),
        .tx_data(p_tx_data), .tx_data_en(p_tx_en), .tx_data_done(p_tx_done),
        .rx_data(p_rx_data), .rx_data_en(p_rx_en), .rx_data_done(p_rx_done),
        .parity_err(p_perr)
    );

    uart_top_ip #(.SYS_CLK_KHZ(SYS_KHZ), .BAUD_RATE_HZ(9600), .OVER_SAMPLING(8),
                  .STOP_BIT_LENGTH(2)) u_s (
        .clk(clk), .rst_n(rst_n), .tx(s_tx), .rx(s_rx),
        .tx_data(s_tx_data), .tx_data_en(s_tx_en), .tx_data_done(s_tx_done),
        .rx_data(s_rx_data), .rx_data_en(s_rx_en), .rx_data_done(s_rx_done),
        .parity_err(s_perr)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line-format model: element k is the k-th symbol on the wire. Unused symbols read 1.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int par,
                                                input int stops, output int n);
        logic [15:0] f;
        int          pos;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        pos = 9;
        if (par != 0) begin
            f[pos] = ($countones(d) % 2 == 1);
            pos++;
        end
        n = pos + stops;
        return f;
    endfunction

    function automatic logic tx_sel(input int which);
        case (which)
            0:       return a_tx;
            1:       return b_tx;
            2:       return p_tx;
            default: return s_tx;
        endcase
    endfunction

    // Waits for the start bit, then samples every symbol near its centre.
    task automatic capture(input int which, input int bitlen, input int n, input string tag,
                           output logic [15:0] bits);
        int waited;
        waited = 0;
        bits   = '1;
        while (tx_sel(which) !== 1'b0 && waited < 8 * bitlen) begin
            @(negedge clk);
            waited++;
        end
        if (tx_sel(which) !== 1'b0) begin
            check({tag, "_start_timeout"}, {15'd0, tx_sel(which)}, 16'd0);
            return;
        end
        repeat (bitlen / 2) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            bits[k] = tx_sel(which);
            if (k < n - 1) repeat (bitlen) @(negedge clk);
        end
    endtask

    // One frame between a and b; the enables are pulsed for one bit time.
    task automatic xfer(input bit a2b, input logic [7:0] d, input string tag);
        logic [15:0] got, exp;
        int          n;
        exp = build_frame(d, 0, 1, n);
        if (a2b) a_tx_data = d;
        else     b_tx_data = d;
        fork
            capture(a2b ? 0 : 1, a2b ? BIT_A : BIT_B, n, tag, got);
            begin
                @(negedge clk);
                if (a2b) begin a_tx_en = 1'b1; b_rx_en = 1'b1; end
                else     begin b_tx_en = 1'b1; a_rx_en = 1'b1; end
                repeat (BIT_A) @(negedge clk);
                if (a2b) begin a_tx_en = 1'b0; b_rx_en = 1'b0; end
                else     begin b_tx_en = 1'b0; a_rx_en = 1'b0; end
            end
        join
        repeat (BIT_A / 2) @(negedge clk);
        check({tag, "_frame"}, got, exp);
        if (a2b) begin
            check({tag, "_rx_data"}, {8'd0, b_rx_data}, {8'd0, d});
            check({tag, "_rx_done"}, {15'd0, b_rx_done}, 16'd1);
            check({tag, "_perr"}, {15'd0, b_perr}, 16'd0);
            check({tag, "_tx_done"}, {15'd0, a_tx_done}, 16'd1);
        end else begin
            check({tag, "_rx_data"}, {8'd0, a_rx_data}, {8'd0, d});
            check({tag, "_rx_done"}, {15'd0, a_rx_done}, 16'd1);
            check({tag, "_perr"}, {15'd0, a_perr}, 16'd0);
            check({tag, "_tx_done"}, {15'd0, b_tx_done}, 16'd1);
        end
    endtask

    task automatic wait_b_done(input int budget, input string tag);
        int c;
        c = 0;
        while (b_rx_done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, {15'd0, b_rx_done}, 16'd1);
    endtask

    // Bit-bangs a frame into p's rx line, followed by one idle bit.
    task automatic inject(input logic [15:0] bits, input int n, input bit check_mid);
        for (int k = 0; k < n; k++) begin
            p_rx = bits[k];
            repeat (BIT_P) @(negedge clk);
            if (check_mid && k == 2) check("p_done_clear_midframe", {15'd0, p_rx_done}, 16'd0);
        end
        p_rx = 1'b1;
        repeat (BIT_P) @(negedge clk);
    endtask

    initial begin
        logic [15:0] got, exp;
        logic [7:0]  d, d2;
        int          n, lows;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_tx", {15'd0, a_tx}, 16'd1);
        check("rst_tx_done", {15'd0, a_tx_done}, 16'd0);
        check("rst_rx_data", {8'd0, a_rx_data}, 16'd0);
        check("rst_rx_done", {15'd0, a_rx_done}, 16'd0);
        check("rst_perr", {15'd0, a_perr}, 16'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // a -> b 0xAB, done within 10 bits + 1%
        fork
            xfer(1'b1, 8'hAB, "ab");
            wait_b_done(BIT_A * 10 + BIT_A / 10, "ab_done_in_time");
        join
        repeat (BIT_A) @(negedge clk);
        check("ab_tx_done_held", {15'd0, a_tx_done}, 16'd1);

        // b -> a 0xCC, done still high one bit later
        xfer(1'b0, 8'hCC, "ba");
        repeat (BIT_A) @(negedge clk);
        check("ba_rx_done_held", {15'd0, a_rx_done}, 16'd1);

        // Random word, then simultaneous full-duplex exchange
        d = 8'($urandom);
        xfer(1'b1, d, "rnd_ab");
        d  = 8'($urandom);
        d2 = 8'($urandom);
        fork
            xfer(1'b1, d, "dup_ab");
            xfer(1'b0, d2, "dup_ba");
        join

        // Parity transmitter: 0x07 has odd weight, so the parity bit is 1
        exp = build_frame(8'h07, 1, 1, n);
        p_tx_data = 8'h07;
        fork
            capture(2, BIT_P, n, "p_tx", got);
            begin
                @(negedge clk);
                p_tx_en = 1'b1;
                repeat (BIT_P) @(negedge clk);
                p_tx_en = 1'b0;
            end
        join
        check("p_tx_frame", got, exp);
        check("p_tx_parity_bit", {15'd0, got[9]}, 16'd1);

        // Parity receiver: good frame, then the same word with the parity bit flipped
        p_rx_en = 1'b1;
        exp = build_frame(8'h07, 1, 1, n);
        inject(exp, n, 1'b1);
        check("p_rx_good_data", {8'd0, p_rx_data}, 16'h07);
        check("p_rx_good_perr", {15'd0, p_perr}, 16'd0);
        check("p_rx_good_done", {15'd0, p_rx_done}, 16'd1);
        exp[9] = ~exp[9];
        inject(exp, n, 1'b0);
        check("p_rx_bad_data", {8'd0, p_rx_data}, 16'h07);
        check("p_rx_bad_perr", {15'd0, p_perr}, 16'd1);

        // A glitch just under 8 samples wide is rejected without touching the outputs
        p_rx = 1'b0;
        repeat (8 * 25 - 12) @(negedge clk);
        p_rx = 1'b1;
        repeat (2 * BIT_P) @(negedge clk);
        check("glitch_rx_data", {8'd0, p_rx_data}, 16'h07);
        check("glitch_perr", {15'd0, p_perr}, 16'd1);
        check("glitch_done", {15'd0, p_rx_done}, 16'd1);
        exp = build_frame(8'h5A, 1, 1, n);
        inject(exp, n, 1'b0);
        check("after_glitch_data", {8'd0, p_rx_data}, 16'h5A);
        check("after_glitch_perr", {15'd0, p_perr}, 16'd0);
        p_rx_en = 1'b0;

        // Two stop bits with the request held high: exactly one frame
        s_tx_data = 8'($urandom);
        exp = build_frame(s_tx_data, 0, 2, n);
        s_tx_en = 1'b1;
        capture(3, BIT_S, n, "s_tx", got);
        check("s_tx_frame", got, exp);
        lows = 0;
        repeat (3 * BIT_S) begin
            @(negedge clk);
            if (s_tx !== 1'b1) lows++;
        end
        check("s_no_second_frame", 16'(lows), 16'd0);
        check("s_tx_done", {15'd0, s_tx_done}, 16'd1);
        s_tx_en = 1'b0;

        // Reset in the middle of a frame
        a_tx_data = 8'($urandom);
        @(negedge clk);
        a_tx_en = 1'b1;
        b_rx_en = 1'b1;
        repeat (BIT_A) @(negedge clk);
        a_tx_en = 1'b0;
        b_rx_en = 1'b0;
        repeat (2 * BIT_A) @(negedge clk);
        check("mid_tx_done_cleared", {15'd0, a_tx_done}, 16'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {15'd0, a_tx}, 16'd1);
        check("mid_rst_tx_done", {15'd0, a_tx_done}, 16'd0);
        check("mid_rst_a_rx_done", {15'd0, a_rx_done}, 16'd0);
        check("mid_rst_b_rx_done", {15'd0, b_rx_done}, 16'd0);
        check("mid_rst_b_rx_data", {8'd0, b_rx_data}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        xfer(1'b1, 8'h3C, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #(10 * 95_000);
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
